// File: rtl/sync_fifo_gen_pkg.sv
// Shared types and helpers for the generic synchronous FIFO.
// Holds the count-width function, the decoded accepted-operation type and the stats width.
package fifo_gen_pkg;

  localparam int STATS_W = 16;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WR    = 2'd1,
    OP_RD    = 2'd2,
    OP_WR_RD = 2'd3
  } fifo_op_e;

  // Occupancy needs one extra bit so that a completely full FIFO is representable.
  function automatic int calc_cw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_gen_if.sv
// Producer/consumer bus of sync_fifo_gen; the stats outputs exist only when FIFO_STATS_EN is defined.
// master = environment driving requests, slave = the FIFO.
interface sync_fifo_gen_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) ();
  import fifo_gen_pkg::*;
  localparam int CW = calc_cw(DEPTH);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  almostfull;
  logic                  empty;
  logic                  almostempty;
  logic [CW-1:0]         count;
`ifdef FIFO_STATS_EN
  logic [STATS_W-1:0]    ovf_cnt;
  logic [STATS_W-1:0]    udf_cnt;
  logic [CW-1:0]         peak_cnt;
`endif

  modport master (
    output data_in, wr_en, rd_en,
`ifdef FIFO_STATS_EN
    input  ovf_cnt, udf_cnt, peak_cnt,
`endif
    input  data_out, wr_ack, overflow, underflow, full, almostfull, empty, almostempty, count
  );

  modport slave (
    input  data_in, wr_en, rd_en,
`ifdef FIFO_STATS_EN
    output ovf_cnt, udf_cnt, peak_cnt,
`endif
    output data_out, wr_ack, overflow, underflow, full, almostfull, empty, almostempty, count
  );

endinterface

// File: rtl/sync_fifo_gen_stats.sv
// Saturating overflow/underflow counters and peak-occupancy tracker (FIFO_STATS_EN builds only).
// Counters lag the registered strobes by one clock; peak tracks the count register in step.
`ifdef FIFO_STATS_EN
module fifo_stats
  import fifo_gen_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  fifo_op_e           op,
  input  logic               ovf_stb,
  input  logic               udf_stb,
  input  logic [CW-1:0]      count,
  output logic [STATS_W-1:0] ovf_cnt,
  output logic [STATS_W-1:0] udf_cnt,
  output logic [CW-1:0]      peak_cnt
);

  logic [CW-1:0] count_nxt;
  assign count_nxt = count + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt  <= '0;
      udf_cnt  <= '0;
      peak_cnt <= '0;
    end else begin
      if (ovf_stb && (ovf_cnt != '1)) ovf_cnt <= ovf_cnt + STATS_W'(1);
      if (udf_stb && (udf_cnt != '1)) udf_cnt <= udf_cnt + STATS_W'(1);
      // Occupancy only rises on a write-only cycle, so that is the only time a new peak can appear.
      if ((op == OP_WR) && (count_nxt > peak_cnt)) peak_cnt <= count_nxt;
    end
  end

endmodule
`endif

// File: rtl/sync_fifo_gen.sv
// Parametrised single-clock FIFO; read data 1 clk after an accepted read; full rejects writes (overflow)
// unless a read frees a slot that cycle. Optional stats block enabled by FIFO_STATS_EN.
module sync_fifo_gen
  import fifo_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_MARGIN  = 1,
  parameter int AE_MARGIN  = 1
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_gen_if.slave bus
);

  localparam int CW = calc_cw(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic                  wr_ack_q, overflow_q, underflow_q;
  logic                  full_w, empty_w, wr_acc, rd_acc;
  fifo_op_e              op;

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);
  assign rd_acc  = bus.rd_en && !empty_w;
  // A full FIFO still takes a write when the same cycle's read frees a slot.
  assign wr_acc  = bus.wr_en && (!full_w || rd_acc);
  assign op      = fifo_op_e'({rd_acc, wr_acc});

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ack_q    <= wr_acc;
      overflow_q  <= bus.wr_en && !wr_acc;
      underflow_q <= bus.rd_en && !rd_acc;
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) begin
        rd_ptr     <= rd_ptr + PW'(1);
        data_out_q <= mem[rd_ptr];
      end
      case (op)
        OP_WR:   count_q <= count_q + CW'(1);
        OP_RD:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
  assign bus.count       = count_q;
  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostfull  = (count_q == CW'(DEPTH - AF_MARGIN));
  assign bus.almostempty = (count_q == CW'(AE_MARGIN));

`ifdef FIFO_STATS_EN
  fifo_stats #(.CW(CW)) u_stats (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .ovf_stb  (overflow_q),
    .udf_stb  (underflow_q),
    .count    (count_q),
    .ovf_cnt  (bus.ovf_cnt),
    .udf_cnt  (bus.udf_cnt),
    .peak_cnt (bus.peak_cnt)
  );
`endif

endmodule

// File: tb/tb_sync_fifo_gen.sv
// Randomised self-checking bench for sync_fifo_gen against a queue-based reference model.
module tb_sync_fifo_gen;
  import fifo_gen_pkg::*;

  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_gen_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo_gen #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout;
  logic          m_ack, m_ovf, m_udf;
  logic [15:0]   m_ovf_cnt, m_udf_cnt;
  int            m_peak;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count",       32'(bus.count),       32'(sz));
    chk("data_out",    32'(bus.data_out),    32'(m_dout));
    chk("wr_ack",      32'(bus.wr_ack),      32'(m_ack));
    chk("overflow",    32'(bus.overflow),    32'(m_ovf));
    chk("underflow",   32'(bus.underflow),   32'(m_udf));
    chk("full",        32'(bus.full),        32'(sz == DEPTH));
    chk("almostfull",  32'(bus.almostfull),  32'(sz == DEPTH - AFM));
    chk("empty",       32'(bus.empty),       32'(sz == 0));
    chk("almostempty", 32'(bus.almostempty), 32'(sz == AEM));
`ifdef FIFO_STATS_EN
    chk("ovf_cnt",  32'(bus.ovf_cnt),  32'(m_ovf_cnt));
    chk("udf_cnt",  32'(bus.udf_cnt),  32'(m_udf_cnt));
    chk("peak_cnt", 32'(bus.peak_cnt), 32'(m_peak));
`endif
  endtask

  task automatic do_reset(input logic wr, input logic rd);
    @(negedge clk);
    rst = 1'b1;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.data_in = DW'($urandom);
    q.delete();
    m_dout = '0; m_ack = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    m_ovf_cnt = '0; m_udf_cnt = '0; m_peak = 0;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] din);
    int   sz;
    logic rok, wok;
    @(negedge clk);
    rst = 1'b0;
    bus.wr_en = wr;
    bus.rd_en = rd;
    bus.data_in = din;
    // Stats counters reflect strobes raised on the previous clock.
    if (m_ovf && m_ovf_cnt != 16'hFFFF) m_ovf_cnt++;
    if (m_udf && m_udf_cnt != 16'hFFFF) m_udf_cnt++;
    sz  = q.size();
    rok = rd && (sz > 0);
    wok = wr && ((sz < DEPTH) || rok);
    if (rok) m_dout = q.pop_front();
    if (wok) q.push_back(din);
    m_ack = wok;
    m_ovf = wr && !wok;
    m_udf = rd && !rok;
    if (q.size() > m_peak) m_peak = q.size();
    @(posedge clk); #1;
    check_all();
  endtask

  initial begin
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = '0;

    // Reset held for two clocks, with requests asserted to show reset wins.
    do_reset(1'b1, 1'b1);
    do_reset(1'b0, 1'b1);

    // Fill to full, then one rejected write.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(16'hA000 + i));
    step(1'b1, 1'b0, 16'hDEAD);
    chk("ovf_at_full", 32'(bus.overflow), 32'd1);

    // Drain in order, then one rejected read.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      chk("drain_order", 32'(bus.data_out), 32'(16'hA000 + i));
    end
    step(1'b0, 1'b1, '0);
    chk("udf_hold", 32'(bus.data_out), 32'h0000A007);

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(16'hA000 + i));
    step(1'b1, 1'b1, 16'hBEEF);
    chk("full_rw_dout", 32'(bus.data_out), 32'h0000A000);
    chk("full_rw_cnt",  32'(bus.count),    32'(DEPTH));
    while (q.size() > 0) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, 16'h1234);
    chk("empty_rw_udf", 32'(bus.underflow), 32'd1);
    chk("empty_rw_ack", 32'(bus.wr_ack),    32'd1);

    // Interleaved pairs at occupancy 3 to wrap the pointers.
    step(1'b1, 1'b0, DW'($urandom));
    step(1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, DW'($urandom));

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

    // Reset mid-stream: stale entries must never come back.
    while (q.size() < 5) step(1'b1, 1'b0, DW'($urandom));
    do_reset(1'b1, 1'b1);
    step(1'b0, 1'b1, '0);
    chk("post_rst_udf", 32'(bus.underflow), 32'd1);
    step(1'b1, 1'b0, 16'h5A5A);
    step(1'b0, 1'b1, '0);
    chk("post_rst_data", 32'(bus.data_out), 32'h00005A5A);
    for (int i = 0; i < 100; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));

`ifdef FIFO_STATS_EN
    do_reset(1'b0, 1'b0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    for (int i = 0; i < DEPTH + 3; i++) step(1'b1, 1'b0, DW'($urandom));
    step(1'b0, 1'b0, '0);
    chk("stats_ovf",  32'(bus.ovf_cnt),  32'd3);
    chk("stats_udf",  32'(bus.udf_cnt),  32'd2);
    chk("stats_peak", 32'(bus.peak_cnt), 32'(DEPTH));
    for (int i = 0; i < 70000; i++) step(1'b1, 1'b0, DW'(i));
    step(1'b0, 1'b0, '0);
    chk("stats_ovf_sat", 32'(bus.ovf_cnt), 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
